// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline (fetch, decode, execute,
// memory, writeback). It resolves load-use hazards, taken-branch squashes
// and data-memory wait states. It also contains the debug halt/step/resume
// FSM, a sticky memory-timeout flag and a saturating stall-cycle counter.
module pipe_ctrl #(
   parameter int CNT_W       = 16,
   parameter int DRAIN_CYC   = 4,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      ir_dc,
   input  logic             v_dc,
   input  logic [31:0]      ir_ex,
   input  logic             v_ex,
   input  logic             cp_ex,
   input  logic             mem_busy,
   input  logic             halt_req,
   input  logic             step_req,
   input  logic             resume_req,
   output logic             s_fe,
   output logic             s_dc,
   output logic             s_ex,
   output logic             s_me,
   output logic             s_wb,
   output logic             flush,
   output logic             halted,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int DRN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
   localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(DRAIN_CYC - 1);
   localparam logic [15:0] TO_LAST = 16'(MEM_TIMEOUT - 1);
   localparam logic [15:0] TO_MAX  = 16'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2,
      ST_STEP   = 2'd3
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;
   logic [DRN_W-1:0] drain_cnt_r;
   logic [DRN_W-1:0] drain_cnt_nxt_s;
   logic [15:0]      to_cnt_r;
   logic             mem_err_r;
   logic [CNT_W-1:0] stall_cnt_r;
   logic             lu_s;
   logic             br_s;
   logic             timeout_s;
   logic [4:0]       stall_vec_s;   // {fe, dc, ex, me, wb}
   logic             flush_s;
   logic             halted_s;
   logic             unused_bits_s;

   // True when the load in execute writes a register that the decode
   // instruction actually reads (U/J formats read no source register).
   function automatic logic load_use(input logic [31:0] dc, input logic dc_v,
                                     input logic [31:0] ex, input logic ex_v);
      logic [4:0] rd;
      logic       use_rs1;
      logic       use_rs2;
      rd = ex[11:7];
      case (dc[6:0])
         OP_LUI, OP_AUIPC, OP_JAL: begin
            use_rs1 = 1'b0;
            use_rs2 = 1'b0;
         end
         OP_OP, OP_STORE, OP_BRANCH: begin
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
         end
         default: begin
            use_rs1 = 1'b1;
            use_rs2 = 1'b0;
         end
      endcase
      return ex_v & dc_v & (ex[6:0] == OP_LOAD) & (rd != 5'd0) &
             ((use_rs1 & (rd == dc[19:15])) | (use_rs2 & (rd == dc[24:20])));
   endfunction

   assign lu_s      = load_use(ir_dc, v_dc, ir_ex, v_ex);
   assign br_s      = v_ex & cp_ex;
   // The counter saturates at MEM_TIMEOUT, so a continuing busy run fires once.
   assign timeout_s = mem_busy & (to_cnt_r == TO_LAST);

   // Instruction fields that play no part in hazard detection.
   assign unused_bits_s = ^{ir_dc[31:25], ir_dc[14:7], ir_ex[31:12]};

   // Stall/flush/halted decode from the current state and this cycle's inputs.
   always_comb begin
      stall_vec_s = 5'b00000;
      flush_s     = 1'b0;
      halted_s    = 1'b0;
      if (rst) begin
         stall_vec_s = 5'b11111;
      end else begin
         case (state_r)
            ST_HALTED: begin
               stall_vec_s = 5'b11111;
               halted_s    = 1'b1;
            end
            ST_RUN, ST_DRAIN, ST_STEP: begin
               if (mem_busy) begin
                  stall_vec_s = 5'b11111;
               end else if (br_s) begin
                  flush_s = 1'b1;          // squashes the load-use victim too
               end else if (lu_s) begin
                  stall_vec_s = 5'b11000;  // bubble enters execute
               end else begin
                  stall_vec_s = 5'b00000;
               end
               if (state_r == ST_DRAIN) begin
                  stall_vec_s[4] = 1'b1;   // no new fetches while draining
               end else begin
                  stall_vec_s[4] = stall_vec_s[4];
               end
            end
            default: begin
               stall_vec_s = 5'b11111;
            end
         endcase
      end
   end

   // Debug FSM next state; a memory timeout overrides every other transition.
   always_comb begin
      state_nxt_s     = state_r;
      drain_cnt_nxt_s = drain_cnt_r;
      if (timeout_s) begin
         state_nxt_s = ST_HALTED;
      end else begin
         case (state_r)
            ST_RUN: begin
               if (halt_req) begin
                  state_nxt_s     = ST_DRAIN;
                  drain_cnt_nxt_s = {DRN_W{1'b0}};
               end else begin
                  state_nxt_s = ST_RUN;
               end
            end
            ST_DRAIN: begin
               if (!halt_req) begin
                  state_nxt_s = ST_RUN;
               end else if (mem_busy) begin
                  state_nxt_s = ST_DRAIN;
               end else if (drain_cnt_r == DRAIN_LAST) begin
                  state_nxt_s = ST_HALTED;
               end else begin
                  drain_cnt_nxt_s = drain_cnt_r + DRN_W'(1);
               end
            end
            ST_HALTED: begin
               if (resume_req) begin
                  state_nxt_s = ST_RUN;
               end else if (step_req && !mem_err_r) begin
                  state_nxt_s = ST_STEP;
               end else begin
                  state_nxt_s = ST_HALTED;
               end
            end
            ST_STEP: begin
               if (mem_busy) begin
                  state_nxt_s = ST_STEP;
               end else begin
                  state_nxt_s = ST_HALTED;
               end
            end
            default: begin
               state_nxt_s = ST_RUN;
            end
         endcase
      end
   end

   // FSM state and drain counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_RUN;
         drain_cnt_r <= {DRN_W{1'b0}};
      end else begin
         state_r     <= state_nxt_s;
         drain_cnt_r <= drain_cnt_nxt_s;
      end
   end

   // Consecutive mem_busy counter and the sticky timeout flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         to_cnt_r  <= 16'd0;
         mem_err_r <= 1'b0;
      end else begin
         if (!mem_busy) begin
            to_cnt_r <= 16'd0;
         end else if (to_cnt_r != TO_MAX) begin
            to_cnt_r <= to_cnt_r + 16'd1;
         end
         if (timeout_s) begin
            mem_err_r <= 1'b1;
         end
      end
   end

   // Saturating count of RUN cycles in which fetch is held.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_r <= {CNT_W{1'b0}};
      end else if ((state_r == ST_RUN) && stall_vec_s[4] && (stall_cnt_r != CNT_MAX)) begin
         stall_cnt_r <= stall_cnt_r + CNT_W'(1'b1);
      end
   end

   assign {s_fe, s_dc, s_ex, s_me, s_wb} = stall_vec_s;
   assign flush     = flush_s;
   assign halted    = halted_s;
   assign mem_err   = mem_err_r;
   assign stall_cnt = stall_cnt_r;

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline (fetch, decode, execute, memory, writeback).
- Drives the per-stage stall inputs s_fe..s_wb and a flush pulse.
- Resolves load-use hazards, taken-branch squashes and data-memory wait states.
- Provides a debug halt / single-step / resume FSM and a saturating stall-cycle counter.

Parameters:
CNT_W, 16, width of stall_cnt
DRAIN_CYC, 4, cycles fetch is held while older instructions drain before HALTED
MEM_TIMEOUT, 255, max consecutive mem_busy cycles before mem_err (range 1..2^16-1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ir_dc  in  32  instruction in decode
v_dc  in  1  decode slot valid
ir_ex  in  32  instruction in execute
v_ex  in  1  execute slot valid
cp_ex  in  1  execute branch/jump taken
mem_busy  in  1  data memory not ready this cycle
halt_req  in  1  debug halt request (level)
step_req  in  1  single-step request (pulse)
resume_req  in  1  resume request (pulse)
s_fe, s_dc, s_ex, s_me, s_wb  out  1 each  stage stall (1 = hold)
flush  out  1  squash decode and execute contents
halted  out  1  FSM in HALTED
mem_err  out  1  sticky memory timeout flag
stall_cnt  out  CNT_W  cycles in RUN with s_fe=1, saturating

Behaviour:
- Stall/flush outputs are combinational from registered state plus current inputs. State, counters and mem_err update on rising clk.
- Reset (rst=1): state=RUN, drain/timeout counters=0, stall_cnt=0, mem_err=0. While rst is high: all s_*=1, flush=0, halted=0.
- Load-use hazard (lu), all must hold:
  - v_ex=1, v_dc=1, ir_ex[6:0]=0000011, rd=ir_ex[11:7]!=0.
  - rd equals rs1=ir_dc[19:15] when the decode opcode is not 0110111, 0010111 or 1101111; or rd equals rs2=ir_dc[24:20] when the decode opcode is 0110011, 0100011 or 1100011.
- Branch flush: br = v_ex & cp_ex.
- RUN priority, highest first:
  1) mem_busy: all s_*=1, flush=0.
  2) br: all s_*=0, flush=1; lu is ignored because its instruction is squashed.
  3) lu: s_fe=s_dc=1, s_ex=s_me=s_wb=0 (bubble into execute), flush=0.
  4) Otherwise all 0.
- Memory timeout:
  - Counter increments on each mem_busy=1 cycle and clears on mem_busy=0.
  - On reaching MEM_TIMEOUT: mem_err<=1 (sticky until rst), FSM goes to HALTED.
- FSM states: RUN, DRAIN, HALTED, STEP.
- RUN:
  - halt_req=1 -> DRAIN with drain counter=0.
  - A halt_req coincident with br still issues flush that cycle.
- DRAIN:
  - s_fe=1; other stages follow the RUN rules (mem_busy stalls all).
  - Counter advances only on cycles without mem_busy.
  - At DRAIN_CYC-1 -> HALTED.
  - halt_req dropping in DRAIN -> RUN.
- HALTED:
  - All s_*=1, flush=0, halted=1.
  - resume_req -> RUN.
  - step_req (without resume_req) -> STEP.
  - resume_req wins when both are asserted.
  - A mem_err-induced HALTED exits only via resume_req; mem_err stays set.
- STEP:
  - Exactly one cycle with RUN rules, except mem_busy keeps STEP until not busy; then -> HALTED.
  - halted=0 during STEP.
- stall_cnt increments when state=RUN and s_fe=1, saturating at 2^CNT_W-1. It is not counted in DRAIN, HALTED or STEP.
- rst asserted mid-DRAIN or mid-STEP returns to RUN next cycle; no partial state is retained.

Test Plan:
- Load-use: ir_ex=lw x5 (0x0002A283), v_ex=1; ir_dc=add x6,x5,x1 (0x00128333), v_dc=1 -> s_fe=s_dc=1, s_ex=s_me=s_wb=0 for 1 cycle; stall_cnt=1. Repeat with rd=x0 -> no stall.
- Branch over hazard: same lu setup plus cp_ex=1 -> flush=1, all s_*=0, stall_cnt unchanged.
- mem_busy high 3 cycles with cp_ex=1 -> all s_*=1, flush=0 for 3 cycles; flush=1 on the 4th. With MEM_TIMEOUT=4 and 4 busy cycles -> mem_err=1, halted=1 next cycle.
- Halt: halt_req=1 in RUN -> s_fe=1 for DRAIN_CYC=4 cycles, then halted=1. step_req pulse -> one cycle all s_*=0, halted=0, then halted=1. resume_req -> RUN.
- Simultaneous step_req and resume_req in HALTED -> RUN (halted=0, stays 0 with halt_req low).
- Saturation: CNT_W=2, 5 consecutive lu cycles -> stall_cnt 1,2,3,3,3. Assert rst -> stall_cnt=0, all s_*=1 during reset.
